// File: rtl/pool_reader.sv
// pool_reader: walks the pooled 14x14 locations of the conv result file and
// streams the eight channel pixels of each location as one 64-bit beat.
module pool_reader #(
    parameter int IMG_W  = 28,
    parameter int POOL_W = 14,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                addr_gen,
    output logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   pixel0,
    input  logic [DATA_W-1:0]   pixel1,
    input  logic [DATA_W-1:0]   pixel2,
    input  logic [DATA_W-1:0]   pixel3,
    input  logic [DATA_W-1:0]   pixel4,
    input  logic [DATA_W-1:0]   pixel5,
    input  logic [DATA_W-1:0]   pixel6,
    input  logic [DATA_W-1:0]   pixel7,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*DATA_W-1:0] out_data,
    output logic [7:0]          out_index,
    output logic                out_last
);
    localparam int COL_W = $clog2(POOL_W);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, DONE} state_t;
    state_t r_state, w_next;
    logic [ADDR_W-1:0] r_row_base, r_col_off;
    logic [COL_W-1:0]  r_col;
    logic              w_fire, w_final;
    assign w_fire   = out_valid && out_ready;
    assign w_final  = out_index == 8'(POOL_W*POOL_W-1);
    assign busy     = r_state inside {ISSUE, WAIT, HOLD};
    assign done     = r_state == DONE;
    assign addr_gen = r_state == ISSUE;
    assign addr     = addr_gen ? r_row_base + r_col_off : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? ISSUE : IDLE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = HOLD;
            HOLD:    w_next = w_fire ? (w_final ? DONE : ISSUE) : HOLD;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    // Address walks row_base (+2*IMG_W per pooled row) plus col_off (+2 per column).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_base <= '0;
            r_col_off  <= '0;
            r_col      <= '0;
            out_index  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_row_base <= '0;
                r_col_off  <= '0;
                r_col      <= '0;
                out_index  <= '0;
            end
            if (r_state == WAIT) begin
                out_valid <= 1'b1;
                out_data  <= {pixel7, pixel6, pixel5, pixel4, pixel3, pixel2, pixel1, pixel0};
                out_last  <= w_final;
            end
            if (r_state == HOLD && w_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                if (!w_final) begin
                    out_index  <= out_index + 8'd1;
                    r_col      <= r_col == COL_W'(POOL_W-1) ? '0 : r_col + COL_W'(1);
                    r_col_off  <= r_col == COL_W'(POOL_W-1) ? '0 : r_col_off + ADDR_W'(2);
                    r_row_base <= r_col == COL_W'(POOL_W-1) ? r_row_base + ADDR_W'(2*IMG_W) : r_row_base;
                end
            end
        end
    end
endmodule

// File: tb/tb_pool_reader.sv
// tb_pool_reader: directed checks of address walk, beat contents, backpressure,
// ignored starts, mid-run reset and start latency for pool_reader.
module tb_pool_reader;
    logic        clk = 0, rst = 1, start = 0, out_ready = 1;
    logic        busy, done, addr_gen, out_valid, out_last;
    logic [9:0]  addr;
    logic [7:0]  pix [8] = '{default: 8'd0};
    logic [63:0] out_data;
    logic [7:0]  out_index;
    int          n_chk = 0, n_pass = 0, beats = 0, dones = 0;

    pool_reader dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .addr_gen(addr_gen), .addr(addr),
        .pixel0(pix[0]), .pixel1(pix[1]), .pixel2(pix[2]), .pixel3(pix[3]),
        .pixel4(pix[4]), .pixel5(pix[5]), .pixel6(pix[6]), .pixel7(pix[7]),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Register file model: channel N holds (a+N) mod 256, data one cycle after the strobe.
    always @(posedge clk) begin
        if (addr_gen) for (int n = 0; n < 8; n++) pix[n] <= 8'(int'(addr) + n);
        if (out_valid && out_ready) beats <= beats + 1;
        if (done) dones <= dones + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_gen"}, addr_gen, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_index"}, out_index, 0);
    endtask

    // Entered in ISSUE of beat 0; walks the image with optional backpressure or reset.
    task automatic run(input int bp_at, input int rst_at);
        int          a;
        logic [63:0] ed;
        for (int i = 0; i < 196; i++) begin
            a = 56 * (i / 14) + 2 * (i % 14);
            for (int n = 0; n < 8; n++) ed[n*8+:8] = 8'(a + n);
            chk("issue_gen", addr_gen, 1);
            chk("issue_addr", addr, 64'(a));
            tick;
            if (i == 50) start = 1;
            chk("wait_gen", addr_gen, 0);
            chk("wait_valid", out_valid, 0);
            tick;
            start = 0;
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, ed);
            chk("hold_index", out_index, 64'(i));
            chk("hold_last", out_last, 64'(i == 195));
            chk("hold_busy", busy, 1);
            if (i == bp_at) begin
                out_ready = 0;
                repeat (10) begin
                    tick;
                    chk("bp_valid", out_valid, 1);
                    chk("bp_data", out_data, ed);
                    chk("bp_index", out_index, 13);
                    chk("bp_gen", addr_gen, 0);
                end
                out_ready = 1;
            end
            if (i == rst_at) begin
                rst = 1;
                #1;
                chk_zero("rst_mid");
                @(posedge clk);
                #1 rst = 0;
                return;
            end
            tick;
        end
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_valid", out_valid, 0);
        start = 1;
        tick;
        start = 0;
        chk("done_once", done, 0);
        chk("idle_gen", addr_gen, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        tick;
        chk_zero("reset");
        tick;
        rst = 0;
        tick;
        chk_zero("idle");
        start = 1;
        tick;
        start = 0;
        chk("lat_busy", busy, 1);
        chk("lat_gen", addr_gen, 1);
        chk("lat_valid", out_valid, 0);
        run(13, -1);
        chk("run1_beats", beats, 196);
        chk("run1_dones", dones, 1);
        repeat (3) tick;
        chk("ignored_start_gen", addr_gen, 0);
        start = 1;
        tick;
        start = 0;
        run(-1, 100);
        repeat (20) begin
            tick;
            chk("post_rst_valid", out_valid, 0);
            chk("post_rst_gen", addr_gen, 0);
        end
        chk("run2_beats", beats, 296);
        chk("run2_dones", dones, 1);
        start = 1;
        tick;
        start = 0;
        run(-1, -1);
        chk("run3_beats", beats, 492);
        chk("run3_dones", dones, 2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
